// File: rtl/tb_input_conditioner.sv
// Button front end for the tail-light sequencer: synchronises, debounces and
// latches the three active-low buttons, and produces the FSM step pulse.
module tb_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_DIV        = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_n,
  input  logic       right_n,
  input  logic       haz_n,
  output logic       left_out,
  output logic       right_out,
  output logic       haz_out,
  output logic       step,
  output logic [2:0] db_level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [2:0]    w_raw;
  logic [2:0]    w_synced;
  logic [2:0]    w_fall;
  logic [2:0]    r_db;
  logic [2:0]    r_db_d;
  logic [2:0]    r_req;
  logic [TW-1:0] r_tick;
  logic          w_step;

  assign w_raw = {haz_n, right_n, left_n};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync <= '1;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
      end
    end

    assign w_synced[g] = r_sync[SYNC_STAGES-1];

    // Any cycle of agreement clears the count, so only an unbroken run is accepted.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_db[g] <= 1'b1;
        r_cnt   <= '0;
      end else if (w_synced[g] == r_db[g]) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db[g] <= w_synced[g];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    // A new press outranks the step consuming the previous one.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_db_d[g] <= 1'b1;
        r_req[g]  <= 1'b0;
      end else begin
        r_db_d[g] <= r_db[g];
        r_req[g]  <= w_fall[g] | (r_req[g] & ~w_step);
      end
    end
  end

  assign w_fall = r_db_d & ~r_db;

  assign w_step = (r_tick == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick <= '0;
    end else if (w_step) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  assign left_out  = ~(r_req[0] | ~r_db[0]);
  assign right_out = ~(r_req[1] | ~r_db[1]);
  assign haz_out   = ~(r_req[2] | ~r_db[2]);
  assign step      = w_step;
  assign db_level  = r_db;

endmodule
